// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters, one op in flight
module alu_arbiter #(
  parameter int FP_ADD_LAT = 3,
  parameter int FP_MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [5:0]  req0_opc,
  input  logic [5:0]  req1_opc,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_imm,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic [5:0]  alu_opc,
  output logic        alu_reset,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state;
  logic        last;
  logic [3:0]  cnt;
  logic        g0, g1;
  logic [5:0]  s_opc;
  logic [31:0] s_a, s_b, s_imm;
  logic [3:0]  lat_m1;
  // grant selection: the requester not granted last wins contention
  always_comb begin
    g0 = state == IDLE && req0_valid && (!req1_valid || last);
    g1 = state == IDLE && req1_valid && (!req0_valid || !last);
    s_opc = g1 ? req1_opc : req0_opc;
    s_a = g1 ? req1_a : req0_a;
    s_b = g1 ? req1_b : req0_b;
    s_imm = g1 ? req1_imm : req0_imm;
    lat_m1 = s_opc == 6'd23 ? 4'(FP_ADD_LAT - 1) : s_opc == 6'd24 ? 4'(FP_MUL_LAT - 1) : 4'd0;
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign alu_reset = ~reset;
  // FSM: latch the granted op, wait out the ALU latency, hold the response until accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      alu_opc <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_imm <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: if (g0 || g1) begin
          alu_opc <= s_opc;
          alu_a <= s_a;
          alu_b <= s_b;
          alu_imm <= s_imm;
          rsp_id <= g1;
          last <= g1;
          cnt <= lat_m1;
          state <= EXEC;
        end
        EXEC: if (cnt == 4'd0) begin
          rsp_result <= alu_opc == 6'd0 ? 32'd0 : alu_opc == 6'd5 ? alu_a :
                        alu_opc == 6'd16 ? alu_imm : alu_result;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FP_ADD_LAT, default 3, meaning cycles from grant to result for OPC 23 (legal 1..15).
REQ-002 SHALL have parameter FP_MUL_LAT, default 4, meaning cycles from grant to result for OPC 24 (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 each, meaning requester N presents an operation.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each, meaning requester N is granted this cycle.
REQ-007 SHALL have ports req0_opc and req1_opc, input, 6 each, meaning the ALU opcode.
REQ-008 SHALL have ports req0_a, req0_b, req0_imm, req1_a, req1_b and req1_imm, input, 32 each, meaning the operands.
REQ-009 SHALL have ports alu_a, alu_b and alu_imm, output, 32 each, meaning operands driven to the shared ALU.
REQ-010 SHALL have port alu_opc, output, 6, meaning the opcode driven to the ALU.
REQ-011 SHALL have port alu_reset, output, 1, the active-high ALU reset.
REQ-012 SHALL have port alu_result, input, 32, the ALU result.
REQ-013 SHALL have port rsp_valid, output, 1, meaning a response is pending.
REQ-014 SHALL have port rsp_ready, input, 1, meaning the consumer accepts the response.
REQ-015 SHALL have port rsp_id, output, 1, the index of the requester that issued the operation.
REQ-016 SHALL have port rsp_result, output, 32, the result of the operation.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and RESP, with at most one operation outstanding.
REQ-018 In IDLE with any reqN_valid high, SHALL grant exactly one requester by asserting its reqN_ready combinationally; the other ready SHALL be 0.
REQ-019 Grant policy SHALL be round-robin: if both are valid, grant the requester not granted last; if only one is valid, grant it.
REQ-020 On the grant edge, SHALL latch opc/a/b/imm and the requester index into holding registers, load latency counter with L-1, and enter EXEC.
REQ-021 L SHALL be FP_ADD_LAT for OPC 23, FP_MUL_LAT for OPC 24, and 1 for every other OPC; the counter SHALL be 4 bits.
REQ-022 alu_a/alu_b/alu_imm/alu_opc SHALL always equal the holding registers, so they hold stable through EXEC and RESP.
REQ-023 In EXEC, when counter = 0, SHALL capture the result into rsp_result and enter RESP; otherwise decrement the counter.
REQ-024 The captured result SHALL be alu_result, except OPC 0 -> 0, OPC 5 -> held a, and OPC 16 -> held imm (ALU bypassed).
REQ-025 rsp_valid SHALL rise at grant edge + L and be high only in RESP; rsp_result and rsp_id SHALL be stable while rsp_valid is high.
REQ-026 In RESP, rsp_valid and rsp_ready high SHALL return the FSM to IDLE on that edge; the next grant is possible in the following cycle.
REQ-027 reqN_ready SHALL be 0 in EXEC and RESP regardless of reqN_valid.
REQ-028 rsp_ready high while rsp_valid is low SHALL be ignored.
REQ-029 alu_reset SHALL equal NOT reset (combinational) and SHALL be 0 otherwise.

Reset
REQ-030 While reset is low, in any state, SHALL force: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, holding registers 0, counter 0, last-granted = 1 (requester 0 wins first contention).
REQ-031 An operation in flight at reset assertion SHALL be discarded with no response.

Verification
REQ-032 Reset low during EXEC of an FP_MUL op -> rsp_valid 0 immediately, alu_reset 1; after release with both valid -> req0_ready=1 first.
REQ-033 req0 sends opc=1, a=5, b=3 -> rsp_valid high 1 edge after grant, rsp_result=8, rsp_id=0.
REQ-034 Both requesters hold valid with opc=2 and rsp_ready=1 -> grants alternate 0,1,0,1 with one grant every 3 cycles.
REQ-035 req1 sends opc=23, a=0x3F800000, b=0x40000000 -> rsp_valid at grant+3, result 0x40400000, rsp_id=1; req0_ready stays 0 meanwhile.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_result/rsp_id unchanged and no grant; rsp_ready=1 -> IDLE the next cycle.
REQ-037 opc=16 with imm=0x1234 -> rsp_result 0x1234; opc=0 -> rsp_result 0.
